wntz_chain_engine: RTL and testbench

- Standalone Winternitz hash-chain sequencer that drives a sha256_core instance through its init/block/digest interface.
- Successor to the fixed-parameter chain FSM embedded in the SHA-256 wrapper, generalised in three ways:
  - W and digest mode (SHA256 n=32 / SHA192 n=24) are per-request.
  - The chain runs over an arbitrary index range [j_start, j_end) instead of always running to 2^w-1.
  - Requests and results use valid/ready handshakes, and invalid requests return an error.
- Sits between the register/host layer and the core.

---
 rtl/wntz_chain_engine.sv | 151 +++++++++++++++
 tb/tb_wntz_chain_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wntz_chain_engine.sv
// rtl/wntz_chain_engine.sv - Winternitz hash-chain sequencer driving a sha256_core
// Runs x <- H(prefix || j || x) for j in [j_start, j_end) with per-request W and digest width.
module wntz_chain_engine #(
  parameter int PREFIX_BYTES = 22,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      zeroize,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PREFIX_BYTES*8-1:0] req_prefix,
  input  logic [255:0]              req_seed,
  input  logic [3:0]                req_w,
  input  logic                      req_n_mode,
  input  logic [CNT_W-1:0]          req_j_start,
  input  logic [CNT_W-1:0]          req_j_end,
  output logic                      core_init,
  output logic [511:0]              core_block,
  input  logic                      core_ready,
  input  logic [255:0]              core_digest,
  input  logic                      core_digest_valid,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [255:0]              rsp_digest,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          cur_j
);
  localparam int PB = PREFIX_BYTES * 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;

  // chk: captured request awaits validation; fin: verdict made, response next cycle
  logic            chk, fin;
  logic [PB-1:0]   prefix_r;
  logic [255:0]    x_reg;
  logic [3:0]      w_r;
  logic            n_mode_r;
  logic [CNT_W-1:0] j_end_r;
  logic            prev_valid;
  logic            done, last, bad, w_legal;
  logic [31:0]     j_max;

  function automatic logic [255:0] mask_of(input logic n);
    return n ? {256{1'b1}} : {{192{1'b1}}, 64'h0};
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign done      = (state == WAIT) & core_digest_valid & ~prev_valid;
  assign last      = ((cur_j + CNT_W'(1)) == j_end_r);

  always_comb begin
    w_legal = (w_r inside {4'd1, 4'd2, 4'd4, 4'd8});
    j_max   = (32'd1 << w_r) - 32'd1;
    bad     = !w_legal || (int'(w_r) > CNT_W) || (32'(j_end_r) > j_max) || (cur_j > j_end_r);
  end

  always_comb begin
    core_block = '0;
    core_block[511 -: PB]     = prefix_r;
    core_block[511 - PB -: 8] = 8'(cur_j);
    if (n_mode_r) begin
      core_block[503 - PB -: 256] = x_reg;
      core_block[247 - PB -: 8]   = 8'h80;
      core_block[63:0]            = 64'((PREFIX_BYTES + 33) * 8);
    end else begin
      core_block[503 - PB -: 192] = x_reg[255:64];
      core_block[311 - PB -: 8]   = 8'h80;
      core_block[63:0]            = 64'((PREFIX_BYTES + 25) * 8);
    end
  end

  always_comb begin
    state_n   = state;
    core_init = 1'b0;
    unique case (state)
      IDLE:  if (req_valid) state_n = ISSUE;
      ISSUE: begin
        if (!chk && fin) begin
          state_n = RESP;
        end else if (!chk && core_ready) begin
          core_init = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT:  if (done) state_n = last ? RESP : ISSUE;
      RESP:  if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (zeroize) begin
      state_n   = IDLE;
      core_init = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk <= 1'b0; fin <= 1'b0; prefix_r <= '0; x_reg <= '0; w_r <= '0;
      n_mode_r <= 1'b0; j_end_r <= '0; cur_j <= '0; prev_valid <= 1'b0;
      rsp_digest <= '0; rsp_err <= 1'b0;
    end else if (zeroize) begin
      chk <= 1'b0; fin <= 1'b0; prefix_r <= '0; x_reg <= '0; w_r <= '0;
      n_mode_r <= 1'b0; j_end_r <= '0; cur_j <= '0; prev_valid <= 1'b0;
      rsp_digest <= '0; rsp_err <= 1'b0;
    end else begin
      prev_valid <= core_digest_valid;
      unique case (state)
        IDLE: if (req_valid) begin
          prefix_r   <= req_prefix;
          x_reg      <= req_seed & mask_of(req_n_mode);
          w_r        <= req_w;
          n_mode_r   <= req_n_mode;
          cur_j      <= req_j_start;
          j_end_r    <= req_j_end;
          chk        <= 1'b1;
          rsp_err    <= 1'b0;
          rsp_digest <= '0;
        end
        ISSUE: begin
          if (chk) begin
            chk <= 1'b0;
            if (bad) begin
              fin     <= 1'b1;
              rsp_err <= 1'b1;
            end else if (cur_j == j_end_r) begin
              fin        <= 1'b1;
              rsp_digest <= x_reg;
            end
          end else if (fin) begin
            fin <= 1'b0;
          end
        end
        WAIT: if (done) begin
          x_reg <= core_digest & mask_of(n_mode_r);
          if (last) rsp_digest <= core_digest & mask_of(n_mode_r);
          else      cur_j <= cur_j + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wntz_chain_engine.sv
// tb/tb_wntz_chain_engine.sv - self-checking bench for wntz_chain_engine
// Core model returns digest = block[511:256] a fixed latency after core_init.
module tb_wntz_chain_engine;
  localparam int P  = 22;
  localparam int CW = 8;

  logic clk = 0, reset_n = 0, zeroize = 0, req_valid = 0, req_n_mode = 0;
  logic req_ready, core_init, rsp_valid, rsp_err, busy;
  logic [P*8-1:0] req_prefix = '0;
  logic [255:0] req_seed = '0, core_digest = '0, rsp_digest;
  logic [3:0] req_w = '0;
  logic [CW-1:0] req_j_start = '0, req_j_end = '0, cur_j;
  logic [511:0] core_block;
  logic core_ready = 1, core_digest_valid = 0, rsp_ready = 0;

  wntz_chain_engine #(.PREFIX_BYTES(P), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .req_valid(req_valid), .req_ready(req_ready), .req_prefix(req_prefix),
    .req_seed(req_seed), .req_w(req_w), .req_n_mode(req_n_mode),
    .req_j_start(req_j_start), .req_j_end(req_j_end),
    .core_init(core_init), .core_block(core_block), .core_ready(core_ready),
    .core_digest(core_digest), .core_digest_valid(core_digest_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest),
    .rsp_err(rsp_err), .busy(busy), .cur_j(cur_j));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int lc = 3;
  int init_cnt = 0;
  logic [511:0] blocks[$];
  logic [511:0] cb;

  // Core model: sample init mid-cycle, digest_valid rises lc cycles after the init cycle
  always begin
    @(negedge clk);
    if (core_init && core_ready) begin
      cb = core_block;
      blocks.push_back(cb);
      init_cnt++;
      @(posedge clk); #1;
      core_ready = 0; core_digest_valid = 0;
      repeat (lc - 1) @(posedge clk);
      #1;
      core_digest = cb[511:256]; core_digest_valid = 1; core_ready = 1;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mask_f(input bit n);
    return n ? {256{1'b1}} : {{192{1'b1}}, 64'h0};
  endfunction

  function automatic logic [511:0] ref_block(input logic [P*8-1:0] pre, input int j,
                                             input logic [255:0] x, input bit n);
    byte unsigned b[64];
    int nb = n ? 32 : 24;
    longint len = longint'((P + 1 + nb) * 8);
    logic [511:0] r;
    foreach (b[i]) b[i] = 0;
    for (int i = 0; i < P; i++) b[i] = pre[(P-1-i)*8 +: 8];
    b[P] = 8'(j);
    for (int i = 0; i < nb; i++) b[P+1+i] = x[(31-i)*8 +: 8];
    b[P+1+nb] = 8'h80;
    for (int i = 0; i < 8; i++) b[56+i] = 8'(len >> (8*(7-i)));
    for (int i = 0; i < 64; i++) r[(63-i)*8 +: 8] = b[i];
    return r;
  endfunction

  task automatic ref_chain(input logic [P*8-1:0] pre, input logic [255:0] seed, input int w,
                           input bit n, input int js, input int je,
                           output bit err, output logic [255:0] dig, output int steps);
    logic [511:0] blk;
    logic [255:0] x;
    bit ok = (w == 1 || w == 2 || w == 4 || w == 8) && (w <= CW) && (je <= (1 << w) - 1) && (js <= je);
    err = !ok; dig = '0; steps = 0;
    if (ok) begin
      x = seed & mask_f(n);
      for (int j = js; j < je; j++) begin
        blk = ref_block(pre, j, x, n);
        x = blk[511:256] & mask_f(n);
        steps++;
      end
      dig = x;
    end
  endtask

  task automatic run_req(input string tag, input logic [P*8-1:0] pre, input logic [255:0] seed,
                         input int w, input bit n, input int js, input int je,
                         input bit exp_err, input int exp_inits);
    bit m_err;
    logic [255:0] m_dig;
    int m_steps, lat, i0, k, exp_lat;
    ref_chain(pre, seed, w, n, js, je, m_err, m_dig, m_steps);
    exp_lat = (exp_err || exp_inits == 0) ? 2 : 1 + exp_inits * (lc + 1);
    blocks.delete();
    i0 = init_cnt;
    @(posedge clk); #1;
    req_prefix = pre; req_seed = seed; req_w = 4'(w); req_n_mode = n;
    req_j_start = CW'(js); req_j_end = CW'(je); req_valid = 1;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 5000) begin @(posedge clk); #1; lat++; end
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
    check({tag, " rsp_err"}, 256'(rsp_err), 256'(exp_err));
    check({tag, " rsp_digest"}, rsp_digest, m_dig);
    check({tag, " core_init count"}, 256'(init_cnt - i0), 256'(exp_inits));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check({tag, " idle after rsp"}, 256'({busy, rsp_valid, req_ready}), 256'(3'b001));
  endtask

  typedef struct {
    int w; bit n; int js; int je; bit err; int inits;
  } vec_t;
  vec_t tbl[9];

  logic [P*8-1:0] pre_nom;
  logic [255:0] seed_aa;

  initial begin
    bit e; logic [255:0] d, held; int st, k, i0, ws[8]; bit seen, stable;
    tbl[0] = '{4, 1, 3, 5, 0, 2};
    tbl[1] = '{4, 0, 3, 5, 0, 2};
    tbl[2] = '{3, 1, 0, 2, 1, 0};
    tbl[3] = '{4, 1, 0, 16, 1, 0};
    tbl[4] = '{4, 1, 6, 5, 1, 0};
    tbl[5] = '{4, 1, 7, 7, 0, 0};
    tbl[6] = '{8, 1, 250, 255, 0, 5};
    tbl[7] = '{1, 0, 0, 1, 0, 1};
    tbl[8] = '{2, 1, 0, 4, 1, 0};
    ws = '{1, 2, 4, 8, 3, 0, 5, 4};
    for (int i = 0; i < P; i++) pre_nom[(P-1-i)*8 +: 8] = 8'(i);
    seed_aa = {32{8'hAA}};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 256'({req_ready, core_init, rsp_valid, rsp_err, busy}), 256'(5'b10000));
    check("reset rsp_digest", rsp_digest, '0);
    check("reset cur_j", 256'(cur_j), '0);
    @(negedge clk); reset_n = 1;

    for (int v = 0; v < 9; v++)
      begin
        run_req($sformatf("vec%0d", v), pre_nom, seed_aa, tbl[v].w, tbl[v].n,
                tbl[v].js, tbl[v].je, tbl[v].err, tbl[v].inits);
        if (v == 0 && blocks.size() == 2) begin
          check("nom blk1 byte22", 256'(blocks[0][511-22*8 -: 8]), 256'(8'h03));
          check("nom blk1 x", blocks[0][511-23*8 -: 256], seed_aa);
          check("nom blk1 byte55", 256'(blocks[0][511-55*8 -: 8]), 256'(8'h80));
          check("nom blk1 len", 256'(blocks[0][63:0]), 256'(64'h1B8));
          check("nom blk2 byte22", 256'(blocks[1][511-22*8 -: 8]), 256'(8'h04));
          check("nom blk1 full", blocks[0][511:256], ref_block(pre_nom, 3, seed_aa, 1)[511:256]);
        end else if (v == 1 && blocks.size() == 2) begin
          check("192 blk byte47", 256'(blocks[0][511-47*8 -: 8]), 256'(8'h80));
          check("192 blk 48..55", 256'(blocks[0][511-48*8 -: 64]), '0);
          check("192 blk len", 256'(blocks[0][63:0]), 256'(64'h178));
          check("192 rsp low", 256'(rsp_digest[63:0]), '0);
        end else if (v < 2) begin
          check($sformatf("vec%0d blocks captured", v), 256'(blocks.size()), 256'(2));
        end
      end

    for (int r = 0; r < 20; r++) begin
      int w = ws[$urandom_range(0, 7)];
      int js = $urandom_range(0, 12);
      int je = ($urandom_range(0, 5) == 0) ? js - 1 : js + $urandom_range(0, 4);
      bit n = 1'($urandom_range(0, 1));
      logic [255:0] sd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (je < 0) je = 0;
      ref_chain(pre_nom, sd, w, n, js, je, e, d, st);
      run_req($sformatf("rnd%0d", r), pre_nom, sd, w, n, js, je, e, st);
    end

    // core_ready held low in ISSUE
    @(posedge clk); #1;
    core_ready = 0;
    req_prefix = pre_nom; req_seed = seed_aa; req_w = 4; req_n_mode = 1;
    req_j_start = 0; req_j_end = 1; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    seen = 0; i0 = init_cnt;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (core_init) seen = 1; end
    check("no init while core busy", 256'(seen), '0);
    @(posedge clk); #1;
    core_ready = 1;
    k = 0;
    while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
    ref_chain(pre_nom, seed_aa, 4, 1, 0, 1, e, d, st);
    check("stall init count", 256'(init_cnt - i0), 256'(1));
    check("stall digest", rsp_digest, d);

    // rsp_ready held low
    stable = 1; held = rsp_digest;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || rsp_digest !== held) stable = 0;
    end
    check("rsp held under backpressure", 256'(stable), 256'(1));
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    check("released to idle", 256'(busy), '0);

    // zeroize while waiting on the core
    lc = 8;
    @(posedge clk); #1;
    req_prefix = pre_nom; req_seed = seed_aa; req_w = 4; req_n_mode = 1;
    req_j_start = 0; req_j_end = 3; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    i0 = init_cnt; k = 0;
    while (init_cnt == i0 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    zeroize = 1;
    @(posedge clk); #1;
    zeroize = 0;
    check("zeroize busy/rsp_valid", 256'({busy, rsp_valid}), '0);
    check("zeroize cur_j", 256'(cur_j), '0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (busy || rsp_valid) seen = 1;
    end
    check("late done ignored", 256'(seen), '0);
    check("no init after zeroize", 256'(init_cnt - i0), 256'(1));
    lc = 3;
    run_req("post-zeroize", pre_nom, ~seed_aa, 4, 0, 2, 5, 0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
